// File: rtl/alarm_pkg.sv
// Shared types, limits and small helpers for the alarm clock core.
// Hours are binary 0..23 internally; minutes/seconds are two BCD digits.
package alarm_pkg;

  typedef enum logic [1:0] {
    ModeRun      = 2'b00,
    ModeSetTime  = 2'b01,
    ModeSetAlarm = 2'b10,
    ModeRunAlt   = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StRinging = 2'b01,
    StSnoozed = 2'b10
  } alarm_state_t;

  typedef logic [3:0] digit_t;

  localparam int unsigned SEC_MAX  = 59;
  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned HOUR_MAX = 23;

  function automatic logic [4:0] hour_inc(input logic [4:0] h);
    return (h == 5'(HOUR_MAX)) ? 5'd0 : h + 5'd1;
  endfunction

  function automatic logic [7:0] hour_to_bcd(input logic [4:0] h);
    digit_t     hi;
    logic [4:0] sub;
    if (h >= 5'd20) begin
      hi  = 4'd2;
      sub = 5'd20;
    end else if (h >= 5'd10) begin
      hi  = 4'd1;
      sub = 5'd10;
    end else begin
      hi  = 4'd0;
      sub = 5'd0;
    end
    return {hi, 4'(h - sub)};
  endfunction

endpackage

// File: rtl/alarm_timekeeper_if.sv
// Control and display bundle between the alarm core and its host/display logic.
interface alarm_timekeeper_if;
  logic [1:0]  mode;
  logic        inc_hour;
  logic        inc_min;
  logic        mode_12h;
  logic        alarm_arm;
  logic        snooze;
  logic        stop;
  logic [15:0] disp_bcd;
  logic [7:0]  sec_bcd;
  logic        pm;
  logic        sec_tick;
  logic        alarm_active;
  logic [1:0]  alarm_state;

  modport master (
    output mode, inc_hour, inc_min, mode_12h, alarm_arm, snooze, stop,
    input  disp_bcd, sec_bcd, pm, sec_tick, alarm_active, alarm_state
  );

  modport slave (
    input  mode, inc_hour, inc_min, mode_12h, alarm_arm, snooze, stop,
    output disp_bcd, sec_bcd, pm, sec_tick, alarm_active, alarm_state
  );
endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter 00..MAX with synchronous clear and enable.
// carry_o is high in the enabled cycle that wraps MAX back to 00.
module bcd_mod_counter
  import alarm_pkg::*;
#(
  parameter int unsigned MAX     = 59,
  parameter int unsigned RST_VAL = 0
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   clr_i,
  input  logic   en_i,
  output digit_t hi_o,
  output digit_t lo_o,
  output logic   carry_o
);

  localparam digit_t MaxHi = digit_t'(MAX / 10);
  localparam digit_t MaxLo = digit_t'(MAX % 10);
  localparam digit_t RstHi = digit_t'(RST_VAL / 10);
  localparam digit_t RstLo = digit_t'(RST_VAL % 10);

  digit_t hi_q, hi_d, lo_q, lo_d;
  logic   at_max;

  assign at_max  = (hi_q == MaxHi) && (lo_q == MaxLo);
  assign carry_o = en_i && !clr_i && at_max;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (clr_i) begin
      hi_d = '0;
      lo_d = '0;
    end else if (en_i) begin
      if (at_max) begin
        hi_d = '0;
        lo_d = '0;
      end else if (lo_q == 4'd9) begin
        hi_d = hi_q + 4'd1;
        lo_d = '0;
      end else begin
        lo_d = lo_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hi_q <= RstHi;
      lo_q <= RstLo;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

endmodule

// File: rtl/alarm_timekeeper.sv
// Time-of-day core: seconds divider, settable time/alarm, alarm FSM with snooze,
// and combinational BCD / 12h display formatting.
module alarm_timekeeper
  import alarm_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 2500,
  parameter int unsigned RING_SEC    = 60,
  parameter int unsigned SNOOZE_MIN  = 5,
  parameter int unsigned ALARM_DEF_H = 7,
  parameter int unsigned ALARM_DEF_M = 0
) (
  input  logic               clk_in,
  input  logic               reset,
  alarm_timekeeper_if.slave  bus
);

  localparam int unsigned DivW     = $clog2(TICK_DIV);
  localparam int unsigned SnzTicks = SNOOZE_MIN * 60;
  localparam int unsigned SnzW     = $clog2(SnzTicks + 1);

  mode_t mode;
  logic  set_time, set_alarm, run_mode;

  assign mode      = mode_t'(bus.mode);
  assign set_time  = (mode == ModeSetTime);
  assign set_alarm = (mode == ModeSetAlarm);
  assign run_mode  = !set_time && !set_alarm;

  // Divider only stops in SET_TIME: time must keep running while the alarm is edited.
  logic [DivW-1:0] div_q, div_d;
  logic            tick, tick_q;

  assign tick = !set_time && (div_q == DivW'(TICK_DIV - 1));

  always_comb begin
    div_d = div_q + DivW'(1);
    if (set_time || tick) div_d = '0;
  end

  digit_t s_hi, s_lo, m_hi, m_lo, am_hi, am_lo;
  logic   s_carry, m_carry, m_en, am_carry_unused;

  assign m_en = set_time ? bus.inc_min : s_carry;

  bcd_mod_counter #(.MAX(SEC_MAX), .RST_VAL(0)) u_sec (
    .clk_i   (clk_in),
    .rst_i   (reset),
    .clr_i   (set_time),
    .en_i    (tick),
    .hi_o    (s_hi),
    .lo_o    (s_lo),
    .carry_o (s_carry)
  );

  bcd_mod_counter #(.MAX(MIN_MAX), .RST_VAL(0)) u_min (
    .clk_i   (clk_in),
    .rst_i   (reset),
    .clr_i   (1'b0),
    .en_i    (m_en),
    .hi_o    (m_hi),
    .lo_o    (m_lo),
    .carry_o (m_carry)
  );

  bcd_mod_counter #(.MAX(MIN_MAX), .RST_VAL(ALARM_DEF_M)) u_alarm_min (
    .clk_i   (clk_in),
    .rst_i   (reset),
    .clr_i   (1'b0),
    .en_i    (set_alarm && bus.inc_min),
    .hi_o    (am_hi),
    .lo_o    (am_lo),
    .carry_o (am_carry_unused)
  );

  logic [4:0] h_q, h_d, ah_q, ah_d;

  // Minute wrap while editing never reaches the hour; only running time carries.
  always_comb begin
    h_d  = h_q;
    ah_d = ah_q;
    if (set_time) begin
      if (bus.inc_hour) h_d = hour_inc(h_q);
    end else if (m_carry) begin
      h_d = hour_inc(h_q);
    end
    if (set_alarm && bus.inc_hour) ah_d = hour_inc(ah_q);
  end

  // Trigger only when running time has just rolled onto hh:mm:00, never on an edit.
  logic match;
  assign match = run_mode && bus.alarm_arm && tick_q && (s_hi == 4'd0) && (s_lo == 4'd0) &&
                 (h_q == ah_q) && (m_hi == am_hi) && (m_lo == am_lo);

  alarm_state_t    state_q, state_d;
  logic [7:0]      ring_q, ring_d;
  logic [SnzW-1:0] snz_q, snz_d;

  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
    snz_d   = snz_q;
    if (!bus.alarm_arm || !run_mode) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (match) begin
            state_d = StRinging;
            ring_d  = 8'(RING_SEC);
          end
        end
        StRinging: begin
          if (bus.stop) begin
            state_d = StIdle;
          end else if (bus.snooze) begin
            state_d = StSnoozed;
            snz_d   = SnzW'(SnzTicks);
          end else if (tick) begin
            if (ring_q <= 8'd1) state_d = StIdle;
            else                ring_d  = ring_q - 8'd1;
          end
        end
        StSnoozed: begin
          if (bus.stop) begin
            state_d = StIdle;
          end else if (tick) begin
            if (snz_q <= SnzW'(1)) begin
              state_d = StRinging;
              ring_d  = 8'(RING_SEC);
            end else begin
              snz_d = snz_q - SnzW'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      div_q  <= '0;
      tick_q <= 1'b0;
      h_q    <= '0;
      ah_q   <= 5'(ALARM_DEF_H);
    end else begin
      div_q  <= div_d;
      tick_q <= tick;
      h_q    <= h_d;
      ah_q   <= ah_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= StIdle;
      ring_q  <= '0;
      snz_q   <= '0;
    end else begin
      state_q <= state_d;
      ring_q  <= ring_d;
      snz_q   <= snz_d;
    end
  end

  logic [4:0] h_sel, h_disp;
  digit_t     dm_hi, dm_lo;

  always_comb begin
    h_sel  = set_alarm ? ah_q : h_q;
    dm_hi  = set_alarm ? am_hi : m_hi;
    dm_lo  = set_alarm ? am_lo : m_lo;
    h_disp = h_sel;
    if (bus.mode_12h) begin
      if (h_sel == 5'd0)       h_disp = 5'd12;
      else if (h_sel > 5'd12)  h_disp = h_sel - 5'd12;
    end
  end

  assign bus.disp_bcd     = {hour_to_bcd(h_disp), dm_hi, dm_lo};
  assign bus.sec_bcd      = {s_hi, s_lo};
  assign bus.pm           = bus.mode_12h && (h_sel >= 5'd12);
  assign bus.sec_tick     = tick;
  assign bus.alarm_active = (state_q == StRinging);
  assign bus.alarm_state  = state_q;

endmodule

// File: tb/tb_alarm_timekeeper.sv
// Bench for alarm_timekeeper: directed scenarios plus random segments, every cycle
// compared against a seconds-of-day reference model.
module tb_alarm_timekeeper;

  localparam int TD = 4;
  localparam int RS = 3;
  localparam int SM = 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alarm_timekeeper_if bus();

  alarm_timekeeper #(
    .TICK_DIV    (TD),
    .RING_SEC    (RS),
    .SNOOZE_MIN  (SM),
    .ALARM_DEF_H (7),
    .ALARM_DEF_M (0)
  ) dut (
    .clk_in (clk),
    .reset  (reset),
    .bus    (bus)
  );

  int checks    = 0;
  int errors    = 0;
  int tick_seen = 0;

  // Reference model: time as seconds of day, alarm as minute of day.
  int m_tsec, m_amin, m_phase, m_state, m_ring, m_snz;
  bit m_ticked;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: wait bound expired", tag);
  endtask

  function automatic logic [7:0] bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int sel_hour();
    return (bus.mode == 2'b10) ? m_amin / 60 : m_tsec / 3600;
  endfunction

  function automatic logic [15:0] exp_disp();
    int h, m;
    h = sel_hour();
    m = (bus.mode == 2'b10) ? m_amin % 60 : (m_tsec / 60) % 60;
    if (bus.mode_12h) begin
      if (h == 0)      h = 12;
      else if (h > 12) h = h - 12;
    end
    return {bcd2(h), bcd2(m)};
  endfunction

  task automatic model_reset();
    m_tsec   = 0;
    m_amin   = 7 * 60;
    m_phase  = 0;
    m_state  = 0;
    m_ring   = 0;
    m_snz    = 0;
    m_ticked = 1'b0;
  endtask

  task automatic check_outputs();
    bit tk;
    tk = (bus.mode != 2'b01) && (m_phase == TD - 1);
    chk("disp_bcd", 32'(bus.disp_bcd), 32'(exp_disp()));
    chk("sec_bcd", 32'(bus.sec_bcd), 32'(bcd2(m_tsec % 60)));
    chk("pm", 32'(bus.pm), 32'(bus.mode_12h && sel_hour() >= 12));
    chk("sec_tick", 32'(bus.sec_tick), 32'(tk));
    chk("alarm_state", 32'(bus.alarm_state), 32'(m_state));
    chk("alarm_active", 32'(bus.alarm_active), 32'(m_state == 1));
  endtask

  task automatic model_update();
    bit run, tk, match;
    int hh, mm, ns;
    run   = (bus.mode == 2'b00) || (bus.mode == 2'b11);
    tk    = (bus.mode != 2'b01) && (m_phase == TD - 1);
    match = run && bus.alarm_arm && m_ticked && (m_tsec % 60 == 0) && (m_tsec / 60 == m_amin);
    ns    = m_state;
    if (!bus.alarm_arm || !run) ns = 0;
    else if (m_state == 0) begin
      if (match) begin ns = 1; m_ring = RS; end
    end else if (m_state == 1) begin
      if (bus.stop) ns = 0;
      else if (bus.snooze) begin ns = 2; m_snz = SM * 60; end
      else if (tk) begin
        m_ring--;
        if (m_ring == 0) ns = 0;
      end
    end else begin
      if (bus.stop) ns = 0;
      else if (tk) begin
        m_snz--;
        if (m_snz == 0) begin ns = 1; m_ring = RS; end
      end
    end
    m_state = ns;
    if (bus.mode == 2'b01) begin
      hh = m_tsec / 3600;
      mm = (m_tsec / 60) % 60;
      if (bus.inc_min)  mm = (mm + 1) % 60;
      if (bus.inc_hour) hh = (hh + 1) % 24;
      m_tsec = hh * 3600 + mm * 60;
    end else if (tk) begin
      m_tsec = (m_tsec + 1) % 86400;
    end
    if (bus.mode == 2'b10) begin
      hh = m_amin / 60;
      mm = m_amin % 60;
      if (bus.inc_min)  mm = (mm + 1) % 60;
      if (bus.inc_hour) hh = (hh + 1) % 24;
      m_amin = hh * 60 + mm;
    end
    m_phase  = (bus.mode == 2'b01 || tk) ? 0 : m_phase + 1;
    m_ticked = tk;
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    if (bus.sec_tick) tick_seen++;
    model_update();
    @(posedge clk);
    #1;
    bus.inc_hour = 1'b0;
    bus.inc_min  = 1'b0;
    bus.snooze   = 1'b0;
    bus.stop     = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic set_time_hm(input int h, input int m);
    int nh, nm, n;
    bus.mode = 2'b01;
    nh = (h - m_tsec / 3600 + 24) % 24;
    nm = (m - (m_tsec / 60) % 60 + 60) % 60;
    n  = (nh > nm) ? nh : nm;
    if (n == 0) n = 1;
    for (int i = 0; i < n; i++) begin
      bus.inc_hour = (i < nh);
      bus.inc_min  = (i < nm);
      step();
    end
  endtask

  task automatic set_alarm_hm(input int h, input int m);
    int nh, nm, n;
    bus.mode = 2'b10;
    nh = (h - m_amin / 60 + 24) % 24;
    nm = (m - m_amin % 60 + 60) % 60;
    n  = (nh > nm) ? nh : nm;
    if (n == 0) n = 1;
    for (int i = 0; i < n; i++) begin
      bus.inc_hour = (i < nh);
      bus.inc_min  = (i < nm);
      step();
    end
  endtask

  task automatic wait_state(input int s, input int bound, input string tag);
    int n = 0;
    while (m_state != s && n < bound) begin
      step();
      n++;
    end
    if (m_state != s) timeout_fail(tag);
  endtask

  task automatic wait_tsec(input int t, input int bound, input string tag);
    int n = 0;
    while (m_tsec != t && n < bound) begin
      step();
      n++;
    end
    if (m_tsec != t) timeout_fail(tag);
  endtask

  task automatic ring_from_midnight(input string tag);
    set_time_hm(0, 0);
    bus.mode = 2'b00;
    wait_state(1, 400, tag);
  endtask

  initial begin
    bus.mode      = 2'b00;
    bus.inc_hour  = 1'b0;
    bus.inc_min   = 1'b0;
    bus.mode_12h  = 1'b0;
    bus.alarm_arm = 1'b0;
    bus.snooze    = 1'b0;
    bus.stop      = 1'b0;
    do_reset();

    chk("rst_disp", 32'(bus.disp_bcd), 32'h0000);
    chk("rst_sec", 32'(bus.sec_bcd), 32'h00);
    chk("rst_tick", 32'(bus.sec_tick), 32'h0);
    chk("rst_state", 32'(bus.alarm_state), 32'h0);
    chk("rst_pm", 32'(bus.pm), 32'h0);

    tick_seen = 0;
    repeat (4) step();
    chk("first_tick_count", 32'(tick_seen), 32'd1);
    chk("first_sec", 32'(bus.sec_bcd), 32'h01);

    // Midnight rollover from 23:59:58.
    set_time_hm(23, 59);
    bus.mode = 2'b00;
    wait_tsec(86398, 400, "pre_wrap");
    repeat (4) step();
    chk("pre_wrap_disp", 32'(bus.disp_bcd), 32'h2359);
    chk("pre_wrap_sec", 32'(bus.sec_bcd), 32'h59);
    repeat (4) step();
    chk("wrap_disp", 32'(bus.disp_bcd), 32'h0000);
    chk("wrap_sec", 32'(bus.sec_bcd), 32'h00);

    // 12h display format.
    bus.mode_12h = 1'b1;
    set_time_hm(0, 0);
    chk("h12_00_disp", 32'(bus.disp_bcd), 32'h1200);
    chk("h12_00_pm", 32'(bus.pm), 32'h0);
    set_time_hm(12, 0);
    chk("h12_12_disp", 32'(bus.disp_bcd), 32'h1200);
    chk("h12_12_pm", 32'(bus.pm), 32'h1);
    set_time_hm(13, 0);
    chk("h12_13_disp", 32'(bus.disp_bcd), 32'h0100);
    chk("h12_13_pm", 32'(bus.pm), 32'h1);
    bus.mode_12h = 1'b0;

    // Alarm at 00:01 rings for RING_SEC ticks.
    bus.mode = 2'b00;
    do_reset();
    set_alarm_hm(0, 1);
    bus.alarm_arm = 1'b1;
    ring_from_midnight("ring1");
    chk("ring1_active", 32'(bus.alarm_active), 32'h1);
    chk("ring1_disp", 32'(bus.disp_bcd), 32'h0001);
    chk("ring1_sec", 32'(bus.sec_bcd), 32'h00);
    wait_state(0, 20, "ring1_end");
    chk("ring1_end_state", 32'(bus.alarm_state), 32'h0);
    chk("ring1_end_sec", 32'(bus.sec_bcd), 32'h03);

    // Snooze, re-ring after SNOOZE_MIN*60 ticks, then stop+snooze together.
    ring_from_midnight("ring2");
    bus.snooze = 1'b1;
    step();
    chk("snoozed_state", 32'(bus.alarm_state), 32'h2);
    tick_seen = 0;
    wait_state(1, 300, "snooze_end");
    chk("snooze_ticks", 32'(tick_seen), 32'd60);
    chk("resnooze_active", 32'(bus.alarm_active), 32'h1);
    bus.stop   = 1'b1;
    bus.snooze = 1'b1;
    step();
    chk("stop_wins_state", 32'(bus.alarm_state), 32'h0);

    // Disarm and mode change force IDLE.
    ring_from_midnight("ring3");
    bus.alarm_arm = 1'b0;
    step();
    chk("disarm_state", 32'(bus.alarm_state), 32'h0);
    bus.alarm_arm = 1'b1;
    ring_from_midnight("ring4");
    bus.mode = 2'b01;
    step();
    chk("settime_state", 32'(bus.alarm_state), 32'h0);
    chk("settime_active", 32'(bus.alarm_active), 32'h0);

    // Minute wrap while editing leaves the hour alone.
    set_time_hm(5, 59);
    bus.inc_min = 1'b1;
    step();
    chk("min_wrap_disp", 32'(bus.disp_bcd), 32'h0500);

    // Reset while ringing.
    ring_from_midnight("ring5");
    do_reset();
    chk("rst_ring_state", 32'(bus.alarm_state), 32'h0);
    chk("rst_ring_disp", 32'(bus.disp_bcd), 32'h0000);

    // Random segments against the model.
    set_alarm_hm(0, 2);
    set_time_hm(0, 1);
    for (int seg = 0; seg < 120; seg++) begin
      int r, len;
      r   = int'($urandom_range(0, 9));
      len = int'($urandom_range(1, 40));
      bus.mode      = (r < 6) ? 2'b00 : (r == 6) ? 2'b01 : (r == 7) ? 2'b10 : 2'b11;
      bus.mode_12h  = ($urandom_range(0, 1) == 1);
      bus.alarm_arm = ($urandom_range(0, 5) != 0);
      for (int i = 0; i < len; i++) begin
        bus.inc_hour = ($urandom_range(0, 7) == 0);
        bus.inc_min  = ($urandom_range(0, 7) == 0);
        bus.snooze   = ($urandom_range(0, 15) == 0);
        bus.stop     = ($urandom_range(0, 31) == 0);
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
